// File: rtl/mem_access_master.sv
// Data-memory initiator: turns one CPU load/store request into memory
// read/write signalling and returns the captured read data on a response.
module mem_access_master #(
    parameter int DATA_WORDS = 2097152,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr1,
    input  logic [AW-1:0] req_addr2,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data1,
    output logic [31:0]   rsp_data2,
    output logic          rsp_error,
    output logic          mem_EN,
    output logic [1:0]    mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_address1,
    output logic [AW-1:0] mem_address2,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   mem_data1,
    input  logic [31:0]   mem_data2
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] OP_LOAD1 = 2'd0;
    localparam logic [1:0] OP_LOAD2 = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [AW-1:0] LIMIT = AW'(DATA_WORDS);

    state_t        state, state_d;
    logic [1:0]    op;
    logic [AW-1:0] addr1, addr2;
    logic [31:0]   wdata;
    logic          en;
    logic          ok;
    logic          accept;

    // Unsigned compare over the full width; no wrap-around
    always_comb begin
        ok = 1'b0;
        unique case (op)
            OP_LOAD1: ok = addr1 < LIMIT;
            OP_LOAD2: ok = (addr1 < LIMIT) && (addr2 < LIMIT);
            OP_STORE: ok = addr1 < LIMIT;
            default:  ok = 1'b0;
        endcase
    end

    assign accept    = en && req_valid && (state == IDLE);
    assign req_ready = en && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_EN    = en;

    assign mem_address1   = addr1;
    assign mem_address2   = addr2;
    assign mem_write_data = wdata;

    always_comb begin
        state_d   = state;
        mem_read  = 2'd0;
        mem_write = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                if (!ok) begin
                    state_d = RESP;
                end else if (op == OP_STORE) begin
                    mem_write = 1'b1;
                    state_d   = RESP;
                end else begin
                    mem_read = (op == OP_LOAD2) ? 2'd2 : 2'd1;
                    state_d  = WAIT;
                end
            end
            WAIT: state_d = RESP;
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            en        <= 1'b0;
            op        <= 2'd0;
            addr1     <= '0;
            addr2     <= '0;
            wdata     <= '0;
            rsp_data1 <= '0;
            rsp_data2 <= '0;
            rsp_error <= 1'b0;
        end else begin
            state <= state_d;
            en    <= 1'b1;
            if (accept) begin
                op    <= req_op;
                addr1 <= req_addr1;
                addr2 <= req_addr2;
                wdata <= req_wdata;
            end
            if (state == ISSUE) begin
                rsp_data1 <= '0;
                rsp_data2 <= '0;
                rsp_error <= !ok;
            end
            // Memory data is registered, so it is valid during WAIT
            if (state == WAIT) begin
                rsp_data1 <= mem_data1;
                rsp_data2 <= (op == OP_LOAD2) ? mem_data2 : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Scoreboard bench for mem_access_master with a registered memory model.
module tb_mem_access_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr1, req_addr2, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data1, rsp_data2;
    logic        rsp_error;
    logic        mem_EN;
    logic [1:0]  mem_read;
    logic        mem_write;
    logic [31:0] mem_address1, mem_address2, mem_write_data;
    logic [31:0] mem_data1 = 32'd0, mem_data2 = 32'd0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [int unsigned];
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [1:0]  last_rd = 2'd0;
    logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;

    mem_access_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr1(req_addr1), .req_addr2(req_addr2),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_error(rsp_error),
        .mem_EN(mem_EN), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address1(mem_address1), .mem_address2(mem_address2),
        .mem_write_data(mem_write_data),
        .mem_data1(mem_data1), .mem_data2(mem_data2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    // Responder model: read data registered one clock after mem_read
    always @(posedge clk) begin
        if (mem_write) mem[mem_address1] = mem_write_data;
        if (mem_read != 2'd0) begin
            mem_data1 <= rd(mem_address1);
            mem_data2 <= rd(mem_address2);
        end
    end

    always @(negedge clk) begin
        if (mem_read != 2'd0) begin
            rd_cnt++;
            last_rd = mem_read;
        end
        if (mem_write) begin
            wr_cnt++;
            last_waddr = mem_address1;
            last_wdata = mem_write_data;
        end
        if (mem_read != 2'd0 && mem_write) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] wd,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input logic eerr, input int elat,
                          input int erd, input int ewr, input bit hold);
        exp_t e;
        int   w, lat, rd0, wr0;
        sb.push_back('{d1: e1, d2: e2, err: eerr});
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr1 = a1;
        req_addr2 = a2;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rsp_valid && lat < 10);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("latency", 32'(lat), 32'(elat));
        e = sb.pop_front();
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_d1", rsp_data1, e.d1);
                check("hold_req_ready", 32'(req_ready), 32'd0);
                @(posedge clk); #1;
            end
        end
        check("rsp_data1", rsp_data1, e.d1);
        check("rsp_data2", rsp_data2, e.d2);
        check("rsp_error", 32'(rsp_error), 32'(e.err));
        check("rd_pulses", 32'(rd_cnt - rd0), 32'(erd));
        check("wr_pulses", 32'(wr_cnt - wr0), 32'(ewr));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int rv;
        mem[32'h6064] = 32'hFFFF_FFF9;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr1 = 32'd0;
        req_addr2 = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_EN", 32'(mem_EN), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_addr1", mem_address1, 32'd0);
        check("rst_rsp_data1", rsp_data1, 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_mem_EN", 32'(mem_EN), 32'd1);

        do_req(2'd2, 32'h64, 32'h0, 32'd5, 32'd0, 32'd0, 1'b0, 1, 0, 1, 0);
        check("store_addr", last_waddr, 32'h64);
        check("store_data", last_wdata, 32'd5);
        do_req(2'd0, 32'h64, 32'h0, 32'd0, 32'd5, 32'd0, 1'b0, 2, 1, 0, 0);
        check("load1_rd_val", 32'(last_rd), 32'd1);
        do_req(2'd1, 32'h64, 32'h6064, 32'd0, 32'd5, 32'hFFFF_FFF9,
               1'b0, 2, 1, 0, 0);
        check("load2_rd_val", 32'(last_rd), 32'd2);
        do_req(2'd0, 32'h20_0000, 32'h0, 32'd0, 32'd0, 32'd0, 1'b1, 1, 0, 0, 0);
        do_req(2'd2, 32'h20_0000, 32'h0, 32'd9, 32'd0, 32'd0, 1'b1, 1, 0, 0, 0);
        do_req(2'd2, 32'h1F_FFFF, 32'h0, 32'hA5A5, 32'd0, 32'd0,
               1'b0, 1, 0, 1, 0);
        do_req(2'd0, 32'h1F_FFFF, 32'h0, 32'd0, 32'hA5A5, 32'd0,
               1'b0, 2, 1, 0, 0);
        do_req(2'd1, 32'h64, 32'h20_0000, 32'd0, 32'd0, 32'd0, 1'b1, 1, 0, 0, 0);
        do_req(2'd3, 32'h64, 32'h64, 32'd0, 32'd0, 32'd0, 1'b1, 1, 0, 0, 0);
        do_req(2'd0, 32'hFFFF_FFFF, 32'h0, 32'd0, 32'd0, 32'd0,
               1'b1, 1, 0, 0, 0);
        do_req(2'd1, 32'h6064, 32'h64, 32'd0, 32'hFFFF_FFF9, 32'd5,
               1'b0, 2, 1, 0, 1);

        // Reset while a load sits in WAIT
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_addr1 = 32'h64;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_mem_EN", 32'(mem_EN), 32'd0);
        check("mid_rst_mem_read", 32'(mem_read), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_data1", rsp_data1, 32'd0);
        check("mid_rst_addr1", mem_address1, 32'd0);
        reset = 1'b1;
        rv = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) rv++;
        end
        check("mid_rst_no_rsp", 32'(rv), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("rd_wr_exclusive", 32'(both_cnt), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
